// File: rtl/identifier_scanner.sv
// Boot-time AXI4-Lite reader for the identifier block.
// Captures six ID words, then checks version and hash.
module identifier_scanner #(
  parameter logic [15:0] EXP_MAJOR      = 16'd1,
  parameter logic [15:0] MIN_MINOR      = 16'd0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [2:0]   err_code,
  output logic [31:0]  hash,
  output logic [127:0] name,
  output logic [31:0]  version,
  output logic         m_arvalid,
  input  logic         m_arready,
  output logic [7:0]   m_araddr,
  input  logic         m_rvalid,
  output logic         m_rready,
  input  logic [31:0]  m_rdata,
  input  logic [1:0]   m_rresp
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CHECK,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [2:0]  idx;
  logic [CW-1:0] cnt;
  logic        live;
  logic        auto_q;
  logic        go;
  logic        to_hit;
  logic        r_hs;
  logic        phase;
  logic [16:0] minor_diff;
  logic [2:0]  chk_code;

  assign to_hit = (cnt == CW'(TIMEOUT_CYCLES));
  assign go     = start | auto_q;
  assign phase  = (state == S_ADDR) || (state == S_DATA);

  assign m_arvalid = (state == S_ADDR) && !to_hit;
  assign m_araddr  = {3'b000, idx, 2'b00};
  // Idle beats are drained, but never while reset is holding us.
  assign m_rready  = live &&
                     ((state == S_IDLE) ||
                      (state == S_DONE) ||
                      ((state == S_DATA) && !to_hit));
  assign r_hs      = (state == S_DATA) && m_rready && m_rvalid;
  assign busy      = phase || (state == S_CHECK);

  assign minor_diff = {1'b0, version[15:0]} - {1'b0, MIN_MINOR};

  always_comb begin
    chk_code = 3'd0;
    if ((version[31:16] != EXP_MAJOR) || minor_diff[16])
      chk_code = 3'd3;
    else if (hash == 32'd0)
      chk_code = 3'd4;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (go) state_n = S_ADDR;
      end
      S_ADDR: begin
        if (to_hit)         state_n = S_DONE;
        else if (m_arready) state_n = S_DATA;
      end
      S_DATA: begin
        if (to_hit)              state_n = S_DONE;
        else if (r_hs) begin
          if (m_rresp != 2'b00)  state_n = S_DONE;
          else if (idx == 3'd5)  state_n = S_CHECK;
          else                   state_n = S_ADDR;
        end
      end
      S_CHECK: state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      live     <= 1'b0;
      auto_q   <= AUTO_START;
      idx      <= 3'd0;
      cnt      <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_code <= 3'd0;
      hash     <= 32'd0;
      name     <= 128'd0;
      version  <= 32'd0;
    end else begin
      live   <= 1'b1;
      auto_q <= 1'b0;
      if ((state_n != state) &&
          ((state_n == S_ADDR) || (state_n == S_DATA)))
        cnt <= '0;
      else if (phase && !to_hit)
        cnt <= cnt + CW'(1);
      unique case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            idx      <= 3'd0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_code <= 3'd0;
            hash     <= 32'd0;
            name     <= 128'd0;
            version  <= 32'd0;
          end
        end
        S_ADDR: begin
          if (to_hit) begin
            err_code <= 3'd2;
            done     <= 1'b1;
          end
        end
        S_DATA: begin
          if (to_hit) begin
            err_code <= 3'd2;
            done     <= 1'b1;
          end else if (r_hs) begin
            if (m_rresp != 2'b00) begin
              err_code <= 3'd1;
              done     <= 1'b1;
            end else begin
              unique case (idx)
                3'd0:    hash           <= m_rdata;
                3'd1:    name[31:0]     <= m_rdata;
                3'd2:    name[63:32]    <= m_rdata;
                3'd3:    name[95:64]    <= m_rdata;
                3'd4:    name[127:96]   <= m_rdata;
                3'd5:    version        <= m_rdata;
                default: ;
              endcase
              if (idx != 3'd5) idx <= idx + 3'd1;
            end
          end
        end
        S_CHECK: begin
          err_code <= chk_code;
          done     <= 1'b1;
          pass     <= (chk_code == 3'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_identifier_scanner.sv
// Bench for identifier_scanner: two instances, each
// driven by a stallable identifier slave model.
module tb_identifier_scanner;

  logic         aclk = 1'b0;
  logic         rst_n   [2];
  logic         start   [2];
  logic         busy    [2];
  logic         done    [2];
  logic         pass    [2];
  logic [2:0]   err     [2];
  logic [31:0]  hash    [2];
  logic [127:0] nm      [2];
  logic [31:0]  ver     [2];
  logic         arvalid [2];
  logic         arready [2];
  logic [7:0]   araddr  [2];
  logic         rvalid  [2];
  logic         rready  [2];
  logic [31:0]  rdata   [2];
  logic [1:0]   rresp   [2];

  logic [31:0]  mem      [2][6];
  int           err_idx  [2];
  int           stall    [2];
  bit           hold_ar  [2];
  bit           pend     [2];
  bit           taken    [2];
  logic [7:0]   paddr    [2];
  int           rdly     [2];
  int           ardly    [2];
  logic [7:0]   addr_log [2][16];
  int           addr_cnt [2];
  bit           pwait    [2];
  logic [7:0]   paddr_w  [2];
  int           stab_err [2];

  int ncmp = 0;
  int nfail = 0;

  always #5 aclk = ~aclk;

  identifier_scanner #(
    .EXP_MAJOR(16'd1), .MIN_MINOR(16'd0),
    .TIMEOUT_CYCLES(8), .AUTO_START(1'b1)
  ) dut_a (
    .aclk(aclk), .aresetn(rst_n[0]), .start(start[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_code(err[0]), .hash(hash[0]), .name(nm[0]),
    .version(ver[0]),
    .m_arvalid(arvalid[0]), .m_arready(arready[0]),
    .m_araddr(araddr[0]),
    .m_rvalid(rvalid[0]), .m_rready(rready[0]),
    .m_rdata(rdata[0]), .m_rresp(rresp[0])
  );

  identifier_scanner #(
    .EXP_MAJOR(16'd1), .MIN_MINOR(16'd4),
    .TIMEOUT_CYCLES(255), .AUTO_START(1'b0)
  ) dut_b (
    .aclk(aclk), .aresetn(rst_n[1]), .start(start[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_code(err[1]), .hash(hash[1]), .name(nm[1]),
    .version(ver[1]),
    .m_arvalid(arvalid[1]), .m_arready(arready[1]),
    .m_araddr(araddr[1]),
    .m_rvalid(rvalid[1]), .m_rready(rready[1]),
    .m_rdata(rdata[1]), .m_rresp(rresp[1])
  );

  task automatic chk(input string tag,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, act, exp);
    end
  endtask

  task automatic observe(input int i);
    if (!rst_n[i]) return;
    if (arvalid[i] && !arready[i]) begin
      if (pwait[i] && araddr[i] != paddr_w[i])
        stab_err[i]++;
      pwait[i]   = 1'b1;
      paddr_w[i] = araddr[i];
    end else begin
      pwait[i] = 1'b0;
    end
    if (arvalid[i] && arready[i]) begin
      pend[i]  = 1'b1;
      paddr[i] = araddr[i];
      rdly[i]  = $urandom_range(0, stall[i]);
      if (addr_cnt[i] < 16)
        addr_log[i][addr_cnt[i]] = araddr[i];
      addr_cnt[i]++;
    end
    if (rvalid[i] && rready[i]) taken[i] = 1'b1;
  endtask

  task automatic drive(input int i);
    int w;
    if (!rst_n[i]) begin
      pend[i] = 0; taken[i] = 0; pwait[i] = 0;
      rvalid[i] = 0; arready[i] = 0; ardly[i] = 0;
      return;
    end
    if (taken[i]) begin
      rvalid[i] = 1'b0;
      taken[i]  = 1'b0;
      pend[i]   = 1'b0;
      ardly[i]  = $urandom_range(0, stall[i]);
    end
    if (pend[i] && !rvalid[i]) begin
      if (rdly[i] == 0) begin
        w = int'(paddr[i][7:2]);
        rvalid[i] = 1'b1;
        rdata[i]  = (w < 6) ? mem[i][w] : 32'h0;
        rresp[i]  = (w == err_idx[i]) ? 2'b10 : 2'b00;
      end else begin
        rdly[i]--;
      end
    end
    if (hold_ar[i] || pend[i] || !arvalid[i]) begin
      arready[i] = 1'b0;
    end else if (ardly[i] == 0) begin
      arready[i] = 1'b1;
    end else begin
      ardly[i]--;
      arready[i] = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge aclk); observe(0);
    @(negedge aclk); drive(0);
  end

  initial forever begin
    @(posedge aclk); observe(1);
    @(negedge aclk); drive(1);
  end

  task automatic model(input int i,
                       output logic [2:0] e,
                       output logic [31:0] h,
                       output logic [127:0] n,
                       output logic [31:0] v,
                       output int na);
    int mm;
    mm = (i == 0) ? 0 : 4;
    e = 0; h = 0; n = 0; v = 0; na = 6;
    for (int w = 0; w < 6; w++) begin
      if (w == err_idx[i]) begin
        e = 1; na = w + 1;
        return;
      end
      if (w == 0)      h = mem[i][w];
      else if (w == 5) v = mem[i][w];
      else             n[32*(w-1) +: 32] = mem[i][w];
    end
    if (v[31:16] != 16'd1 || int'(v[15:0]) < mm) e = 3;
    else if (h == 0) e = 4;
  endtask

  task automatic check_scan(input int i, input string tag);
    logic [2:0]   e;
    logic [31:0]  h;
    logic [127:0] n;
    logic [31:0]  v;
    int na;
    model(i, e, h, n, v, na);
    chk({tag, "_err"}, err[i], e);
    chk({tag, "_pass"}, pass[i], e == 0);
    chk({tag, "_done"}, done[i], 1);
    chk({tag, "_busy"}, busy[i], 0);
    chk({tag, "_hash"}, hash[i], h);
    chk({tag, "_name"}, nm[i], n);
    chk({tag, "_ver"}, ver[i], v);
    chk({tag, "_naddr"}, addr_cnt[i], na);
    for (int k = 0; k < addr_cnt[i] && k < 16; k++)
      chk({tag, "_addr"}, addr_log[i][k], 8'(k * 4));
  endtask

  task automatic run_scan(input int i, input int repulse,
                          output int n, output int bn,
                          output int an);
    addr_cnt[i] = 0;
    ardly[i] = $urandom_range(0, stall[i]);
    n = 0; bn = 0; an = 0;
    start[i] = 1'b1;
    while (n < 2000) begin
      @(posedge aclk);
      n++;
      @(negedge aclk);
      start[i] = (repulse != 0 && n == repulse);
      if (busy[i]) bn++;
      if (arvalid[i]) an++;
      if (done[i]) break;
    end
    start[i] = 1'b0;
    chk("scan_done", done[i], 1);
  endtask

  typedef struct {
    int          inst;
    logic [31:0] hw;
    logic [31:0] vw;
    int          eidx;
    logic [2:0]  err;
    int          cyc;
  } vec_t;

  vec_t vt [11];

  task automatic load(input int i, input logic [31:0] h,
                      input logic [31:0] v);
    mem[i][0] = h;
    mem[i][1] = 32'h54534554;
    mem[i][2] = 32'h0;
    mem[i][3] = 32'h0;
    mem[i][4] = 32'h0;
    mem[i][5] = v;
  endtask

  initial begin
    int n, bn, an;
    logic [15:0] mj, mn;
    vt[0]  = '{0, 32'hDEADBEEF, 32'h00010000, -1, 3'd0, 14};
    vt[1]  = '{0, 32'hDEADBEEF, 32'h00020005, -1, 3'd3, 14};
    vt[2]  = '{0, 32'h00000000, 32'h00010000, -1, 3'd4, 14};
    vt[3]  = '{0, 32'h00000000, 32'h00020000, -1, 3'd3, 14};
    vt[4]  = '{0, 32'h12345678, 32'h00000007, -1, 3'd3, 14};
    vt[5]  = '{0, 32'hDEADBEEF, 32'h00010000,  2, 3'd1,  7};
    vt[6]  = '{0, 32'hDEADBEEF, 32'h00010000,  0, 3'd1,  3};
    vt[7]  = '{0, 32'hDEADBEEF, 32'h0001ABCD,  5, 3'd1, 13};
    vt[8]  = '{1, 32'hDEADBEEF, 32'h00010003, -1, 3'd3, 14};
    vt[9]  = '{1, 32'hDEADBEEF, 32'h00010004, -1, 3'd0, 14};
    vt[10] = '{1, 32'h00000001, 32'h0001FFFF, -1, 3'd0, 14};

    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 0; start[i] = 0; err_idx[i] = -1;
      stall[i] = 0; hold_ar[i] = 0; addr_cnt[i] = 0;
      stab_err[i] = 0; rvalid[i] = 0; arready[i] = 0;
      rdata[i] = 0; rresp[i] = 0;
      load(i, 32'hDEADBEEF, 32'h00010004);
    end
    mem[0][5] = 32'h00010000;

    repeat (3) @(negedge aclk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_ctrl", {busy[i], done[i], pass[i], err[i],
          arvalid[i], araddr[i], rready[i]}, 0);
      chk("reset_fields", {hash[i], ver[i], nm[i][63:0]}, 0);
    end

    rst_n[0] = 1; rst_n[1] = 1;
    n = 0; bn = 0;
    while (n < 100 && !done[0]) begin
      @(posedge aclk);
      n++;
      @(negedge aclk);
      if (busy[0]) bn++;
    end
    chk("auto_cycles", n, 14);
    chk("auto_busy_cycles", bn, 13);
    chk("auto_ver", ver[0], 32'h00010000);
    chk("auto_hash", hash[0], 32'hDEADBEEF);
    check_scan(0, "auto");
    chk("noauto_idle", {busy[1], done[1]}, 0);

    foreach (vt[k]) begin
      load(vt[k].inst, vt[k].hw, vt[k].vw);
      err_idx[vt[k].inst] = vt[k].eidx;
      run_scan(vt[k].inst, 0, n, bn, an);
      chk($sformatf("vec%0d_err", k), err[vt[k].inst], vt[k].err);
      chk($sformatf("vec%0d_cyc", k), n, vt[k].cyc);
      check_scan(vt[k].inst, $sformatf("vec%0d", k));
    end
    err_idx[0] = -1;
    err_idx[1] = -1;

    hold_ar[0] = 1;
    run_scan(0, 0, n, bn, an);
    hold_ar[0] = 0;
    chk("tmo_err", err[0], 3'd2);
    chk("tmo_cycles", n, 10);
    chk("tmo_arvalid_cycles", an, 8);
    chk("tmo_pass", pass[0], 0);
    chk("tmo_arvalid_low", arvalid[0], 0);

    stall[0] = 5;
    for (int it = 0; it < 40; it++) begin
      mj = 16'($urandom_range(0, 2));
      mn = 16'($urandom);
      mem[0][0] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      for (int w = 1; w < 5; w++) mem[0][w] = $urandom;
      mem[0][5] = {mj, mn};
      err_idx[0] = ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(0, 5)) : -1;
      run_scan(0, 0, n, bn, an);
      check_scan(0, $sformatf("rnd%0d", it));
    end
    chk("araddr_stable", stab_err[0], 0);
    stall[0] = 0;
    err_idx[0] = -1;

    load(1, 32'hCAFEF00D, 32'h00010009);
    start[1] = 1;
    n = 0;
    while (n < 100 &&
           !(busy[1] && rready[1] && araddr[1] == 8'h0C)) begin
      @(posedge aclk);
      n++;
      @(negedge aclk);
      start[1] = 0;
    end
    start[1] = 0;
    chk("mid_reached", araddr[1], 8'h0C);
    rst_n[1] = 0;
    #1;
    chk("mid_reset_ctrl", {busy[1], done[1], pass[1], err[1],
        arvalid[1], araddr[1], rready[1]}, 0);
    chk("mid_reset_hash", hash[1], 0);
    chk("mid_reset_name", nm[1], 0);
    chk("mid_reset_ver", ver[1], 0);
    repeat (3) @(negedge aclk);
    rst_n[1] = 1;
    repeat (5) @(negedge aclk);
    chk("mid_idle_ctrl", {busy[1], done[1], pass[1], err[1],
        arvalid[1], araddr[1]}, 0);
    chk("mid_idle_fields", {hash[1], ver[1], nm[1][63:0]}, 0);
    run_scan(1, 4, n, bn, an);
    chk("restart_cycles", n, 14);
    check_scan(1, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
